ysyx_25040129_wbu: RTL

Write-back unit and register scoreboard for the single-issue RV32E core. It accepts completed results from the EXU (fixed latency) and the LSU (variable latency) over valid/ready handshakes and arbitrates them onto the register file's single write port. It also tracks which architectural registers have a write pending and gives the decoder a hazard signal, so no forwarding network is required.

---
 rtl/ysyx_25040129_wbu_pkg.sv | 7 +
 rtl/ysyx_25040129_scoreboard.sv | 40 ++++
 rtl/ysyx_25040129_wbu.sv | 72 +++++++
 3 files changed

// File: rtl/ysyx_25040129_wbu_pkg.sv
// Shared core-wide widths: register index width, datapath width, register count.
// The regfile, IDU and WBU all size themselves from here.
package ysyx_25040129_wbu_pkg;
  localparam int REGS_DIG = 4;
  localparam int XLEN     = 32;
  localparam int NREGS    = 1 << REGS_DIG;
endpackage

// File: rtl/ysyx_25040129_scoreboard.sv
// Register scoreboard: one busy bit per architectural register, set on issue,
// cleared on commit, with a combinational decode-stall lookup.
module ysyx_25040129_scoreboard #(
  parameter int REGS_DIG = ysyx_25040129_wbu_pkg::REGS_DIG
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set_en,
  input  logic [REGS_DIG-1:0]       set_id,
  input  logic                      clr_en,
  input  logic [REGS_DIG-1:0]       clr_id,
  input  logic [REGS_DIG-1:0]       src1_id,
  input  logic [REGS_DIG-1:0]       src2_id,
  input  logic                      waw_en,
  input  logic [REGS_DIG-1:0]       waw_id,
  output logic [(1<<REGS_DIG)-1:0]  busy,
  output logic                      hazard
);
  import ysyx_25040129_wbu_pkg::*;

  localparam int NR = 1 << REGS_DIG;

  logic [NR-1:0] busy_q, busy_nxt;

  // Clear first so a same-edge set of the same register wins; x0 never busy.
  always_comb begin
    busy_nxt = busy_q;
    if (clr_en) busy_nxt[clr_id] = 1'b0;
    if (set_en) busy_nxt[set_id] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_nxt;
  end

  assign busy   = busy_q;
  assign hazard = !rst && (busy_q[src1_id] || busy_q[src2_id] || (waw_en && busy_q[waw_id]));
endmodule

// File: rtl/ysyx_25040129_wbu.sv
// Write-back unit: LSU-over-EXU fixed-priority arbiter onto the single
// register-file write port, plus the pending-write scoreboard for decode.
module ysyx_25040129_wbu #(
  parameter int REGS_DIG = ysyx_25040129_wbu_pkg::REGS_DIG,
  parameter int XLEN     = ysyx_25040129_wbu_pkg::XLEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      iss_valid,
  input  logic                      iss_wen,
  input  logic [REGS_DIG-1:0]       iss_rd,
  input  logic [REGS_DIG-1:0]       src1_id,
  input  logic [REGS_DIG-1:0]       src2_id,
  output logic                      hazard,
  input  logic                      exu_valid,
  output logic                      exu_ready,
  input  logic                      exu_wen,
  input  logic [REGS_DIG-1:0]       exu_rd,
  input  logic [XLEN-1:0]           exu_result,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [REGS_DIG-1:0]       lsu_rd,
  input  logic [XLEN-1:0]           lsu_result,
  output logic                      reg_write,
  output logic [REGS_DIG-1:0]       rd,
  output logic [XLEN-1:0]           result,
  output logic [(1<<REGS_DIG)-1:0]  busy
);
  import ysyx_25040129_wbu_pkg::*;

  logic lsu_fire, exu_fire;

  // Loads win: the LSU cannot be back-pressured, the EXU simply waits.
  assign lsu_ready = !rst;
  assign exu_ready = !rst && !lsu_valid;
  assign lsu_fire  = lsu_valid && lsu_ready;
  assign exu_fire  = exu_valid && exu_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write <= 1'b0;
      rd        <= '0;
      result    <= '0;
    end else if (lsu_fire) begin
      reg_write <= |lsu_rd;
      rd        <= lsu_rd;
      result    <= lsu_result;
    end else if (exu_fire) begin
      reg_write <= exu_wen && (|exu_rd);
      rd        <= exu_rd;
      result    <= exu_result;
    end else begin
      reg_write <= 1'b0;
    end
  end

  // Busy clears on the same edge the regfile samples the write port.
  ysyx_25040129_scoreboard #(.REGS_DIG(REGS_DIG)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (iss_valid && iss_wen && (|iss_rd)),
    .set_id  (iss_rd),
    .clr_en  (reg_write),
    .clr_id  (rd),
    .src1_id (src1_id),
    .src2_id (src2_id),
    .waw_en  (iss_wen),
    .waw_id  (iss_rd),
    .busy    (busy),
    .hazard  (hazard)
  );
endmodule
